// File: rtl/switch_debouncer_pkg.sv
// rtl/switch_debouncer_pkg.sv - shared constants and types for the switch debouncer
// Purpose: clock frequency constant and the per-channel filter state type.
// Ports: none (package).
package switch_debouncer_pkg;

  // Internal HSOSC frequency; DEBOUNCE_CYCLES defaults are derived from it.
  localparam int CLK_HZ = 48_000_000;

  // Per-channel filter state: IDLE while the synchronised input matches the
  // clean level, COUNT while a candidate change is being timed.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } filt_state_e;

endpackage

// File: rtl/switch_debouncer_if.sv
// rtl/switch_debouncer_if.sv - switch input / debounced output bundle
// Purpose: groups the raw switch levels and the conditioned outputs.
// Signals:
//   s_raw   - raw switch levels, asynchronous to clk
//   s_clean - debounced levels
//   s_rise  - one-cycle pulse on s_clean 0->1, per bit
//   s_fall  - one-cycle pulse on s_clean 1->0, per bit
//   busy    - a change is pending on at least one channel
// Modports: master drives s_raw (switch side), slave is the debouncer.
interface switch_debouncer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_clean;
  logic [WIDTH-1:0] s_rise;
  logic [WIDTH-1:0] s_fall;
  logic             busy;

  modport master (
    output s_raw,
    input  s_clean,
    input  s_rise,
    input  s_fall,
    input  busy
  );

  modport slave (
    input  s_raw,
    output s_clean,
    output s_rise,
    output s_fall,
    output busy
  );

endinterface

// File: rtl/switch_debouncer_channel.sv
// rtl/switch_debouncer_channel.sv - one-bit synchroniser plus debounce filter
// Purpose: brings one raw switch bit into the clk domain and accepts a new
//          level only after it has differed from the clean level for
//          DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      - clock
//   reset_n  - synchronous active-low reset
//   i_raw    - raw switch bit, asynchronous
//   o_clean  - debounced level
//   o_rise   - one-cycle pulse when o_clean goes 0->1
//   o_fall   - one-cycle pulse when o_clean goes 1->0
//   o_busy   - counter is non-zero (change pending)
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clean;
  logic             r_rise;
  logic             r_fall;
  filt_state_e      r_state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      // Plain two-flop chain; nothing but r_sync2 is allowed past it.
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync2 == r_clean) begin
        // Matches (or bounced back): drop any partial count.
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end else if (r_cnt == CNT_MAX) begin
        // Held long enough: accept and pulse in the same cycle.
        r_clean <= r_sync2;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_state <= ST_COUNT;
      end
    end
  end

  // COUNT is held exactly while the counter is non-zero.
  assign o_busy  = (r_state == ST_COUNT);
  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - multi-channel switch synchroniser and debouncer
// Purpose: WIDTH independent debounce channels for the DIP-switch inputs,
//          giving clean levels and rise/fall pulses in the clk domain.
// Ports:
//   clk      - internal 48 MHz oscillator clock
//   reset_n  - synchronous active-low reset
//   sw       - switch_debouncer_if slave (s_raw in; s_clean, s_rise,
//              s_fall, busy out)
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 200
) (
  input  logic                clk,
  input  logic                reset_n,
  switch_debouncer_if.slave   sw
);

  logic [WIDTH-1:0] w_clean;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_busy;

  genvar g;
  for (g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (sw.s_raw[g]),
      .o_clean (w_clean[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g]),
      .o_busy  (w_busy[g])
    );
  end

  assign sw.s_clean = w_clean;
  assign sw.s_rise  = w_rise;
  assign sw.s_fall  = w_fall;
  // Each term is a flop output, so busy stays glitch-free.
  assign sw.busy    = |w_busy;

endmodule
